// File: rtl/mem_indirect_seq_pkg.sv
// mem_indirect_seq_pkg: LC-3b opcode type, MEM-stage sequencer states and indirect-phase codes
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {IDLE, PTR, FINAL, DONE} mem_seq_state_t;

   localparam logic [1:0] IND_PTR   = 2'b00;
   localparam logic [1:0] IND_FINAL = 2'b01;
   localparam logic [1:0] IND_DONE  = 2'b10;

   function automatic logic is_indirect(input lc3b_opcode op);
      return op == op_ldi || op == op_sti;
   endfunction

endpackage

// File: rtl/mem_indirect_seq_wait_timer.sv
// seq_wait_timer: counts memory wait cycles, saturates at WAIT_LIMIT-1 and raises a sticky timeout
//   clk, reset   clock, synchronous active-high reset
//   active       sequencer is waiting on memory (PTR or FINAL)
//   clr          resp seen or state changing this cycle
//   timeout_err  sticky, cleared only by reset
module seq_wait_timer #(
   parameter int WAIT_LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic clr,
   output logic timeout_err
);

   localparam int W = $clog2(WAIT_LIMIT);
   localparam logic [W-1:0] MAX = W'(WAIT_LIMIT - 1);

   logic [W-1:0] wait_cnt;
   logic         inc;

   assign inc = active && !clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         wait_cnt    <= clr ? '0 : (inc && wait_cnt != MAX) ? wait_cnt + 1'b1 : wait_cnt;
         timeout_err <= timeout_err || (inc && wait_cnt == MAX);
      end
   end

endmodule

// File: rtl/mem_indirect_seq.sv
// mem_indirect_seq: MEM-stage sequencer running LDI/STI as pointer fetch + final access
//   op_code, req_valid, addr_in, wdata_in   instruction in MEM stage
//   resp, rdata                             memory completion strobe and read data
//   reset_counter                           clear request from stall logic
//   counter                                 indirect phase 00 ptr fetch, 01 final, 10 complete
//   mem_address                             ptr_q during final access, else addr_in
//   ptr_q, ldata_q                          latched pointer word and final load data
//   busy, timeout_err                       mid-transaction, sticky wait timeout
module mem_indirect_seq
   import lc3b_types::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int WAIT_LIMIT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  lc3b_opcode            op_code,
   input  logic                  req_valid,
   input  logic [DATA_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic                  resp,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  reset_counter,
   output logic [1:0]            counter,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] ptr_q,
   output logic [DATA_WIDTH-1:0] ldata_q,
   output logic                  busy,
   output logic                  timeout_err
);

   mem_seq_state_t state, st, state_n;
   lc3b_opcode     op_q;
   logic           unused;

   // store data is handled by the datapath; the sequencer only steers the address
   assign unused      = ^wdata_in;
   assign mem_address = counter == IND_FINAL ? ptr_q : addr_in;

   // an upset counter of 11 parks the sequencer in DONE until reset_counter
   always_comb begin
      st      = counter == 2'b11 ? DONE : state;
      state_n = reset_counter ? IDLE :
                st == IDLE    ? (req_valid && is_indirect(op_code) ? PTR : IDLE) :
                st == PTR     ? (resp ? FINAL : PTR) :
                st == FINAL   ? (resp ? DONE : FINAL) : DONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= IND_PTR;
         op_q    <= op_br;
         ptr_q   <= '0;
         ldata_q <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         counter <= state_n == FINAL ? IND_FINAL : state_n == DONE ? IND_DONE : IND_PTR;
         busy    <= state_n == PTR || state_n == FINAL;
         if (st == IDLE && state_n == PTR) op_q <= op_code;
         if (st == PTR && state_n == FINAL) ptr_q <= rdata;
         if (st == FINAL && state_n == DONE && op_q == op_ldi) ldata_q <= rdata;
      end
   end

   seq_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .active      (st == PTR || st == FINAL),
      .clr         (resp || state_n != st),
      .timeout_err (timeout_err)
   );

endmodule

// File: tb/tb_mem_indirect_seq.sv
// tb_mem_indirect_seq: randomized self-checking bench for mem_indirect_seq against a transaction model
module tb_mem_indirect_seq;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset, req_valid, resp, reset_counter;
   lc3b_opcode  op_code;
   logic [15:0] addr_in, wdata_in, rdata, mem_address, ptr_q, ldata_q;
   logic [1:0]  counter;
   logic        busy, timeout_err;

   int          n_chk = 0, n_err = 0;
   logic [15:0] mem [logic [15:0]];
   logic [15:0] m_ptr = '0, m_ld = '0;
   logic        m_to = 1'b0;

   always #5 clk = ~clk;

   mem_indirect_seq #(.DATA_WIDTH(16), .WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .op_code(op_code), .req_valid(req_valid),
      .addr_in(addr_in), .wdata_in(wdata_in), .resp(resp), .rdata(rdata),
      .reset_counter(reset_counter), .counter(counter), .mem_address(mem_address),
      .ptr_q(ptr_q), .ldata_q(ldata_q), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic check_state(input string tag, input logic [1:0] c, input logic b);
      chk({tag, "_counter"}, {14'd0, counter}, {14'd0, c});
      chk({tag, "_busy"}, {15'd0, busy}, {15'd0, b});
      chk({tag, "_ptr"}, ptr_q, m_ptr);
      chk({tag, "_ldata"}, ldata_q, m_ld);
      chk({tag, "_timeout"}, {15'd0, timeout_err}, {15'd0, m_to});
   endtask

   task automatic accept(input logic ldi, input logic [15:0] a);
      op_code = ldi ? op_ldi : op_sti;
      req_valid = 1'b1;
      addr_in = a;
      wdata_in = 16'($urandom);
      resp = 1'b0;
      reset_counter = 1'b0;
      #1 chk("req_addr", mem_address, a);
      tick;
      check_state("accept", 2'b00, 1'b1);
      req_valid = 1'b0;
      op_code = lc3b_opcode'($urandom_range(0, 15));
   endtask

   task automatic run_ind(input logic ldi, input logic [15:0] a, input int l1, input int l2);
      logic [15:0] p;
      p = mem_rd(a);
      accept(ldi, a);
      for (int i = 0; i < l1; i++) begin
         #1 chk("ptr_addr", mem_address, a);
         tick;
         check_state("ptr_wait", 2'b00, 1'b1);
      end
      resp = 1'b1;
      rdata = p;
      #1 chk("ptr_addr", mem_address, a);
      tick;
      resp = 1'b0;
      rdata = 16'($urandom);
      m_ptr = p;
      check_state("ptr_done", 2'b01, 1'b1);
      for (int i = 0; i < l2; i++) begin
         #1 chk("fin_addr", mem_address, p);
         tick;
         check_state("fin_wait", 2'b01, 1'b1);
      end
      resp = 1'b1;
      rdata = mem_rd(p);
      #1 chk("fin_addr", mem_address, p);
      tick;
      resp = 1'b0;
      if (ldi) m_ld = mem_rd(p);
      check_state("final", 2'b10, 1'b0);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
         resp = 1'($urandom);
         rdata = 16'($urandom);
         #1 chk("done_addr", mem_address, a);
         tick;
         resp = 1'b0;
         check_state("done_hold", 2'b10, 1'b0);
      end
      reset_counter = 1'b1;
      tick;
      reset_counter = 1'b0;
      check_state("rc", 2'b00, 1'b0);
   endtask

   task automatic run_plain(input int n);
      lc3b_opcode ops [5];
      ops = '{op_ldr, op_str, op_ldb, op_stb, op_trap};
      for (int i = 0; i < n; i++) begin
         op_code = ops[$urandom_range(0, 4)];
         req_valid = 1'b1;
         addr_in = 16'($urandom);
         resp = 1'($urandom);
         rdata = 16'($urandom);
         #1 chk("plain_addr", mem_address, addr_in);
         tick;
         check_state("plain", 2'b00, 1'b0);
      end
      req_valid = 1'b0;
      resp = 1'b0;
   endtask

   initial begin
      logic [15:0] p;
      reset = 1'b1;
      req_valid = 1'b0;
      resp = 1'b0;
      reset_counter = 1'b0;
      op_code = op_br;
      addr_in = 16'h1234;
      wdata_in = '0;
      rdata = '0;
      tick;
      tick;
      reset = 1'b0;
      check_state("reset", 2'b00, 1'b0);
      chk("reset_addr", mem_address, 16'h1234);

      mem[16'h3000] = 16'h4000;
      mem[16'h4000] = 16'hBEEF;
      mem[16'h2000] = 16'h5000;
      run_ind(1'b1, 16'h3000, 0, 0);
      chk("ldi_ldata", ldata_q, 16'hBEEF);
      run_ind(1'b0, 16'h2000, 3, 0);
      chk("sti_ptr", ptr_q, 16'h5000);
      run_plain(4);

      accept(1'b1, 16'h0ACE);
      resp = 1'b1;
      reset_counter = 1'b1;
      rdata = 16'hDEAD;
      tick;
      resp = 1'b0;
      reset_counter = 1'b0;
      check_state("rc_wins", 2'b00, 1'b0);
      run_plain(2);

      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 4) == 0) run_plain(int'($urandom_range(1, 3)));
         else run_ind(1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      p = mem_rd(16'h1111);
      accept(1'b1, 16'h1111);
      for (int i = 1; i <= 4; i++) begin
         tick;
         if (i == 4) m_to = 1'b1;
         check_state("timeout", 2'b00, 1'b1);
      end
      resp = 1'b1;
      rdata = p;
      tick;
      m_ptr = p;
      rdata = mem_rd(p);
      tick;
      resp = 1'b0;
      m_ld = mem_rd(p);
      check_state("late_resp", 2'b10, 1'b0);
      reset_counter = 1'b1;
      tick;
      reset_counter = 1'b0;
      check_state("rc_to", 2'b00, 1'b0);

      p = mem_rd(16'h7770);
      accept(1'b1, 16'h7770);
      resp = 1'b1;
      rdata = p;
      tick;
      resp = 1'b0;
      m_ptr = p;
      check_state("pre_reset", 2'b01, 1'b1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      m_ptr = '0;
      m_ld = '0;
      m_to = 1'b0;
      check_state("mid_reset", 2'b00, 1'b0);
      chk("reset_addr2", mem_address, 16'h7770);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
